alu_seq: RTL and testbench

Parametrised, registered successor to the team's 2-bit combinational ALU. It adds operand width scaling, a start/busy/done handshake, an iterative shift-add multiplier and a zero flag. It sits between the lab register file and the result bus: operands are captured on `start`, and a registered result is presented with a one-cycle `done` pulse.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_seq.sv | 103 ++++++++++
 tb/tb_alu_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the registered ALU and its multiplier.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH iterations after load.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    // prod is the accumulator after the current iteration, so the top can capture it on the final edge.
    assign prod = mplier[0] ? (acc + mcand) : acc;
    assign last = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; MUL is delegated to the iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           sel,
    output logic [2*WIDTH-1:0]   Y,
    output logic                 zero,
    output logic                 busy,
    output logic                 done
);

    state_t             state;
    state_t             state_next;
    logic               mul_load;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_last;
    logic               wr_en;
    logic [2*WIDTH-1:0] wr_val;
    logic [2*WIDTH-1:0] alu_res;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;

    assign ext_a = {{WIDTH{1'b0}}, A};
    assign ext_b = {{WIDTH{1'b0}}, B};
    assign busy  = (state == ST_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .a    (A),
        .b    (B),
        .prod (mul_prod),
        .last (mul_last)
    );

    // Subtraction in 2*WIDTH bits gives the sign-extended difference directly.
    always_comb begin
        alu_res = '0;
        case (sel)
            OP_ADD:  alu_res = ext_a + ext_b;
            OP_SUB:  alu_res = ext_a - ext_b;
            OP_AND:  alu_res = ext_a & ext_b;
            OP_OR:   alu_res = ext_a | ext_b;
            OP_XOR:  alu_res = ext_a ^ ext_b;
            OP_LTU:  alu_res = {{(2*WIDTH-1){1'b0}}, (A < B)};
            OP_RSV:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        wr_en      = 1'b0;
        wr_val     = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        wr_en  = 1'b1;
                        wr_val = alu_res;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    wr_en      = 1'b1;
                    wr_val     = mul_prod;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            Y     <= '0;
            zero  <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= wr_en;
            if (wr_en) begin
                Y    <= wr_val;
                zero <= (wr_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=4 and WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst4, rst8;
    logic        start4, start8;
    logic [3:0]  A4, B4;
    logic [7:0]  A8, B8;
    logic [2:0]  sel4, sel8;
    logic [7:0]  Y4;
    logic [15:0] Y8;
    logic        zero4, zero8, busy4, busy8, done4, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .A(A4), .B(B4), .sel(sel4),
        .Y(Y4), .zero(zero4), .busy(busy4), .done(done4)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .A(A8), .B(B8), .sel(sel8),
        .Y(Y8), .zero(zero8), .busy(busy8), .done(done8)
    );

    // Reference result straight from the operation definitions, masked to 2*w bits.
    function automatic longint ref_alu(input longint a, input longint b, input int s, input int w);
        longint m;
        m = (longint'(1) << (2 * w)) - 1;
        case (s)
            0: return (a + b) & m;
            1: return (a - b) & m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a * b) & m;
            6: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Issues one op on dut4 and waits for done; lat counts edges after the accepting edge, -1 on timeout.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                          output logic [7:0] y, output logic z, output int lat);
        @(negedge clk);
        A4 = a; B4 = b; sel4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done4) lat = -1;
        y = Y4;
        z = zero4;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                          output logic [15:0] y, output logic z, output int lat);
        @(negedge clk);
        A8 = a; B8 = b; sel8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) lat = -1;
        y = Y8;
        z = zero8;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        A4 = '0; B4 = '0; sel4 = '0; A8 = '0; B8 = '0; sel8 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst4 = 1'b0; rst8 = 1'b0;
        checks += 5;
        if (Y4 !== 8'h00)  begin errors++; $display("[TB] FAIL reset_y4: got %0h expected 0", Y4); end
        if (zero4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero4: got %0b expected 1", zero4); end
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy4: got %0b expected 0", busy4); end
        if (done4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done4: got %0b expected 0", done4); end
        if (Y8 !== 16'h0 || zero8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dut8: got Y=%0h zero=%0b busy=%0b done=%0b expected 0/1/0/0",
                     Y8, zero8, busy8, done8);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        A4 = 4'd9; B4 = 4'd8; sel4 = OP_ADD; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks += 4;
        if (Y4 !== 8'h11)   begin errors++; $display("[TB] FAIL add_y: got %0h expected 11", Y4); end
        if (zero4 !== 1'b0) begin errors++; $display("[TB] FAIL add_zero: got %0b expected 0", zero4); end
        if (done4 !== 1'b1) begin errors++; $display("[TB] FAIL add_done: got %0b expected 1", done4); end
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL add_busy: got %0b expected 0", busy4); end
        @(posedge clk); #1;
        checks += 2;
        if (done4 !== 1'b0) begin errors++; $display("[TB] FAIL add_done_pulse: got %0b expected 0", done4); end
        if (Y4 !== 8'h11 || busy4 !== 1'b0) begin
            errors++; $display("[TB] FAIL add_hold: got Y=%0h busy=%0b expected 11/0", Y4, busy4);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        A4 = 4'd3; B4 = 4'd5; sel4 = OP_SUB; start4 = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (Y4 !== 8'hFE || zero4 !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_sub: got Y=%0h zero=%0b expected fe/0", Y4, zero4);
        end
        if (done4 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %0b expected 1", done4); end
        @(negedge clk);
        A4 = 4'hA; B4 = 4'h5; sel4 = OP_AND;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks += 2;
        if (Y4 !== 8'h00 || zero4 !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_and: got Y=%0h zero=%0b expected 0/1", Y4, zero4);
        end
        if (done4 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %0b expected 1", done4); end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done3: got %0b expected 0", done4); end
    endtask

    task automatic test_mul4_ignore_start();
        int busy_cycles;
        int guard;
        @(negedge clk);
        A4 = 4'd15; B4 = 4'd15; sel4 = OP_MUL; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (!done4 && guard < 40) begin
            if (busy4) busy_cycles++;
            @(negedge clk);
            if (busy_cycles == 2) begin
                start4 = 1'b1; sel4 = OP_ADD; A4 = 4'd1; B4 = 4'd1;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        start4 = 1'b0;
        checks += 4;
        if (done4 !== 1'b1) begin errors++; $display("[TB] FAIL mul4_timeout: got done=%0b expected 1", done4); end
        if (busy_cycles != 4) begin errors++; $display("[TB] FAIL mul4_busy_len: got %0d expected 4", busy_cycles); end
        if (Y4 !== 8'hE1 || zero4 !== 1'b0) begin
            errors++; $display("[TB] FAIL mul4_y: got Y=%0h zero=%0b expected e1/0", Y4, zero4);
        end
        if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL mul4_busy_end: got %0b expected 0", busy4); end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0 || Y4 !== 8'hE1) begin
            errors++; $display("[TB] FAIL mul4_ignored_add: got done=%0b Y=%0h expected 0/e1", done4, Y4);
        end
    endtask

    task automatic test_mul8();
        logic [15:0] y;
        logic z;
        int lat;
        do_op8(8'hFF, 8'h02, OP_MUL, y, z, lat);
        checks += 2;
        if (y !== 16'h01FE || z !== 1'b0) begin
            errors++; $display("[TB] FAIL mul8_ff_x2: got Y=%0h zero=%0b expected 1fe/0", y, z);
        end
        if (lat != 8) begin errors++; $display("[TB] FAIL mul8_latency: got %0d expected 8", lat); end
        do_op8(8'h5A, 8'h00, OP_MUL, y, z, lat);
        checks += 2;
        if (y !== 16'h0 || z !== 1'b1) begin
            errors++; $display("[TB] FAIL mul8_by_zero: got Y=%0h zero=%0b expected 0/1", y, z);
        end
        if (lat != 8) begin errors++; $display("[TB] FAIL mul8_zero_latency: got %0d expected 8", lat); end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] y;
        logic z;
        int lat;
        int stray;
        do_op4(4'd9, 4'd8, OP_ADD, y, z, lat);
        @(negedge clk);
        A4 = 4'd7; B4 = 4'd9; sel4 = OP_MUL; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("[TB] FAIL rstmul_busy: got %0b expected 1", busy4); end
        @(posedge clk); #1;
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || Y4 !== 8'h00 || zero4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmul_clear: got busy=%0b Y=%0h zero=%0b done=%0b expected 0/0/1/0",
                     busy4, Y4, zero4, done4);
        end
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done4 !== 1'b0 || busy4 !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("[TB] FAIL rstmul_stray_done: got %0d cycles expected 0", stray); end
        do_op4(4'd3, 4'd2, OP_MUL, y, z, lat);
        checks++;
        if (y !== 8'd6 || z !== 1'b0 || lat != 4) begin
            errors++; $display("[TB] FAIL rstmul_after: got Y=%0h zero=%0b lat=%0d expected 6/0/4", y, z, lat);
        end
    endtask

    task automatic test_ltu_rsv();
        logic [7:0] y;
        logic z;
        int lat;
        do_op4(4'd2, 4'd3, OP_LTU, y, z, lat);
        checks++;
        if (y !== 8'd1 || lat != 0) begin errors++; $display("[TB] FAIL ltu_2_3: got Y=%0h lat=%0d expected 1/0", y, lat); end
        do_op4(4'd3, 4'd3, OP_LTU, y, z, lat);
        checks++;
        if (y !== 8'd0 || z !== 1'b1) begin errors++; $display("[TB] FAIL ltu_3_3: got Y=%0h zero=%0b expected 0/1", y, z); end
        do_op4(4'd9, 4'd8, OP_ADD, y, z, lat);
        do_op4(4'd7, 4'd6, OP_RSV, y, z, lat);
        checks++;
        if (y !== 8'd0 || z !== 1'b1 || lat != 0) begin
            errors++; $display("[TB] FAIL reserved: got Y=%0h zero=%0b lat=%0d expected 0/1/0", y, z, lat);
        end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0) begin errors++; $display("[TB] FAIL reserved_pulse: got %0b expected 0", done4); end
    endtask

    task automatic test_random();
        logic [7:0]  y4;
        logic [15:0] y8;
        logic        z;
        int          lat;
        logic [3:0]  a4, b4;
        logic [7:0]  a8, b8;
        logic [2:0]  s;
        longint      exp;
        for (int i = 0; i < 30; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); s = 3'($urandom_range(0, 7));
            do_op4(a4, b4, s, y4, z, lat);
            exp = ref_alu(longint'(a4), longint'(b4), int'(s), 4);
            checks++;
            if (longint'(y4) !== exp || z !== (exp == 0) || lat != ((s == OP_MUL) ? 4 : 0)) begin
                errors++;
                $display("[TB] FAIL rand4 sel=%0d a=%0h b=%0h: got Y=%0h zero=%0b lat=%0d expected Y=%0h lat=%0d",
                         s, a4, b4, y4, z, lat, exp, (s == OP_MUL) ? 4 : 0);
            end
        end
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s = 3'($urandom_range(0, 7));
            do_op8(a8, b8, s, y8, z, lat);
            exp = ref_alu(longint'(a8), longint'(b8), int'(s), 8);
            checks++;
            if (longint'(y8) !== exp || z !== (exp == 0) || lat != ((s == OP_MUL) ? 8 : 0)) begin
                errors++;
                $display("[TB] FAIL rand8 sel=%0d a=%0h b=%0h: got Y=%0h zero=%0b lat=%0d expected Y=%0h lat=%0d",
                         s, a8, b8, y8, z, lat, exp, (s == OP_MUL) ? 8 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul4_ignore_start();
        test_mul8();
        test_reset_mid_mul();
        test_ltu_rsv();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
